// File: rtl/sd_pkg.sv
// Shared types and constants for the NVRAM <-> SD sequencer.
// State encoding plus sector and LBA geometry.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACKH = 2'd1,
    ACKL = 2'd2
  } sd_state_t;

  localparam int SECTOR_BYTES = 512;
  localparam int LBA_W        = 32;
  localparam int SEC_SHIFT    = $clog2(SECTOR_BYTES);

  // Sectors needed to hold a byte count, rounded up.
  function automatic logic [54:0] bytes_to_sec(
    input logic [63:0] bytes
  );
    logic [54:0] whole;
    whole = bytes[63:SEC_SHIFT];
    return whole + {54'd0, |bytes[SEC_SHIFT-1:0]};
  endfunction

endpackage

// File: rtl/nvram_sd_ctrl.sv
// Backup-RAM <-> SD image sector transfer sequencer.
// Walks sd_lba 0..last with a rd/wr + ack handshake.
module nvram_sd_ctrl
  import sd_pkg::*;
#(
  parameter int SECTORS = 64,
  parameter int SEC_W   = 6
) (
  input  logic             clk_sys,
  input  logic             RESET_n,
  input  logic             downloading,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic [63:0]      img_size,
  input  logic             bk_load,
  input  logic             bk_save,
  input  logic             autosave_en,
  input  logic             osd_status,
  input  logic             nvram_we,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             bk_ena,
  output logic             bk_loading,
  output logic             bk_busy,
  output logic             bk_dirty,
  output logic             bk_done
);

  localparam logic [SEC_W:0] N_MAX =
    (SEC_W+1)'(SECTORS);

  sd_state_t        r_state;
  sd_state_t        w_next;

  logic             r_dl_q;
  logic             r_load_q;
  logic             r_save_q;
  logic             r_osd_q;
  logic             r_ena;
  logic             r_dir_ld;
  logic             r_done;
  logic             r_dirty;
  logic [SEC_W-1:0] r_lba;
  logic [SEC_W-1:0] r_last;

  logic [54:0]      w_secs;
  logic             w_hi;
  logic [SEC_W:0]   w_n_raw;
  logic [SEC_W:0]   w_n;
  logic [SEC_W:0]   w_cnt;
  logic [SEC_W-1:0] w_last_nx;

  logic             w_dl_rise;
  logic             w_dl_fall;
  logic             w_load_rise;
  logic             w_save_rise;
  logic             w_osd_rise;
  logic             w_idle_ok;
  logic             w_go_ld;
  logic             w_go_sv;
  logic             w_start;
  logic             w_ack_lo;
  logic             w_fin;
  logic             w_step;
  logic             w_dirty_set;
  logic             w_dirty_clr;

  // Image size in sectors, clamped to the NVRAM size.
  assign w_secs  = bytes_to_sec(img_size);
  assign w_hi    = |(img_size[63:SEC_SHIFT] >> SEC_W);
  assign w_n_raw = (|(w_secs >> (SEC_W+1)))
                   ? N_MAX
                   : w_secs[SEC_W:0];
  assign w_n     = (w_hi || (w_n_raw > N_MAX))
                   ? N_MAX
                   : w_n_raw;

  assign w_dl_rise   = downloading & ~r_dl_q;
  assign w_dl_fall   = ~downloading & r_dl_q;
  assign w_load_rise = bk_load & ~r_load_q;
  assign w_save_rise = bk_save & ~r_save_q;
  assign w_osd_rise  = osd_status & ~r_osd_q;

  // Triggers only act when idle with a usable image.
  assign w_idle_ok = (r_state == IDLE) & r_ena;
  assign w_go_ld   = w_idle_ok
                   & (w_load_rise | w_dl_fall)
                   & (w_n != '0);
  assign w_go_sv   = w_idle_ok & ~w_go_ld
                   & (w_save_rise
                      | (w_osd_rise & autosave_en & r_dirty));
  assign w_start   = w_go_ld | w_go_sv;

  assign w_cnt     = w_go_ld ? w_n : N_MAX;
  assign w_last_nx = w_cnt[SEC_W-1:0] - SEC_W'(1);

  assign w_ack_lo = (r_state == ACKL) & ~sd_ack;
  assign w_fin    = w_ack_lo & (r_lba == r_last);
  assign w_step   = w_ack_lo & ~w_fin;

  // Core writes while not loading mark NVRAM dirty.
  assign w_dirty_set = nvram_we & ~bk_loading;
  assign w_dirty_clr = w_go_sv | (w_fin & r_dir_ld);

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic for the sector handshake.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_next = ACKH;
      ACKH: if (sd_ack)  w_next = ACKL;
      ACKL: begin
        if (w_fin)       w_next = IDLE;
        else if (w_step) w_next = ACKH;
      end
      default:           w_next = IDLE;
    endcase
  end

  // Output decode from state and direction.
  always_comb begin
    bk_busy    = (r_state != IDLE);
    bk_loading = bk_busy & r_dir_ld;
    sd_rd      = (r_state == ACKH) & r_dir_ld;
    sd_wr      = (r_state == ACKH) & ~r_dir_ld;
    sd_lba     = LBA_W'(r_lba);
    bk_ena     = r_ena;
    bk_dirty   = r_dirty;
    bk_done    = r_done;
  end

  // Input edge detectors.
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_dl_q   <= 1'b0;
      r_load_q <= 1'b0;
      r_save_q <= 1'b0;
      r_osd_q  <= 1'b0;
    end else begin
      r_dl_q   <= downloading;
      r_load_q <= bk_load;
      r_save_q <= bk_save;
      r_osd_q  <= osd_status;
    end
  end

  // Sector pointer, end marker and direction.
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_lba    <= '0;
      r_last   <= '0;
      r_dir_ld <= 1'b0;
    end else if (w_start) begin
      r_lba    <= '0;
      r_last   <= w_last_nx;
      r_dir_ld <= w_go_ld;
    end else if (w_step) begin
      r_lba    <= r_lba + SEC_W'(1);
    end
  end

  // Completion pulse lands with the return to idle.
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) r_done <= 1'b0;
    else          r_done <= w_fin;
  end

  // Image presence: a new download invalidates it.
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_ena <= 1'b0;
    end else if (downloading & img_mounted
                 & ~img_readonly) begin
      r_ena <= 1'b1;
    end else if (w_dl_rise) begin
      r_ena <= 1'b0;
    end
  end

  // Dirty flag; a same-cycle set beats the clear.
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) r_dirty <= 1'b0;
    else          r_dirty <= w_dirty_set
                           | (r_dirty & ~w_dirty_clr);
  end

endmodule

// File: tb/tb_nvram_sd_ctrl.sv
// Self-checking bench for nvram_sd_ctrl.
// Random ack latency and image sizes against a sector-count model.
module tb_nvram_sd_ctrl;

  logic        clk_sys = 1'b0;
  logic        RESET_n = 1'b0;
  logic        downloading = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = '0;
  logic        bk_load = 1'b0;
  logic        bk_save = 1'b0;
  logic        autosave_en = 1'b0;
  logic        osd_status = 1'b0;
  logic        nvram_we = 1'b0;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        bk_ena;
  logic        bk_loading;
  logic        bk_busy;
  logic        bk_dirty;
  logic        bk_done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit wr;
    int lba;
    bit ld;
  } req_t;

  req_t log_q[$];
  int   done_cnt = 0;
  bit   prev_req = 1'b0;
  bit   ack_en = 1'b1;
  int   ack_dly = 3;
  int   ack_wait = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_sd_ctrl #(.SECTORS(64), .SEC_W(6)) dut (
    .clk_sys      (clk_sys),
    .RESET_n      (RESET_n),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .bk_load      (bk_load),
    .bk_save      (bk_save),
    .autosave_en  (autosave_en),
    .osd_status   (osd_status),
    .nvram_we     (nvram_we),
    .sd_ack       (sd_ack),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .bk_busy      (bk_busy),
    .bk_dirty     (bk_dirty),
    .bk_done      (bk_done)
  );

  // Request logger: one entry per rising request.
  always @(negedge clk_sys) begin
    if ((sd_rd | sd_wr) && !prev_req)
      log_q.push_back('{sd_wr, int'(sd_lba), bk_loading});
    prev_req = sd_rd | sd_wr;
    if (bk_done === 1'b1) done_cnt++;
  end

  // HPS ack model with random latency.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && (sd_rd || sd_wr) && !sd_ack) begin
        if (ack_wait >= ack_dly) begin
          sd_ack   = 1'b1;
          ack_wait = 0;
          ack_dly  = $urandom_range(1, 4);
        end else begin
          ack_wait++;
        end
      end else if (sd_ack && !(sd_rd || sd_wr)) begin
        sd_ack = 1'b0;
      end
    end
  end

  // Reference: sectors to load for a given image size.
  function automatic int n_of(longint unsigned sz);
    if (sz >= 64 * 512) return 64;
    return int'((sz + 511) / 512);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk_sys);
    #1;
  endtask

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    bk_load = 1'b1;
    tick(2);
    bk_load = 1'b0;
    tick(1);
  endtask

  task automatic pulse_save();
    bk_save = 1'b1;
    tick(2);
    bk_save = 1'b0;
    tick(1);
  endtask

  task automatic pulse_we();
    nvram_we = 1'b1;
    tick(1);
    nvram_we = 1'b0;
    tick(1);
  endtask

  // Wait for the transfer (or a quiet window) and check the log.
  task automatic expect_xfer(string tag, bit wr, int n,
                             int c0);
    int t;
    int bad;
    t = 0;
    bad = 0;
    if (n > 0) begin
      while (done_cnt == c0 && t < 3000) begin
        tick(1);
        t++;
      end
      tick(2);
      check({tag, ".done"}, 64'(done_cnt - c0), 64'd1);
    end else begin
      tick(40);
    end
    check({tag, ".nreq"}, 64'(log_q.size()), 64'(n));
    foreach (log_q[i])
      if (log_q[i].wr != wr || log_q[i].lba != i ||
          log_q[i].ld != !wr)
        bad++;
    check({tag, ".seq"}, 64'(bad), 64'd0);
    check({tag, ".idle"},
          64'({bk_busy, bk_loading, sd_rd, sd_wr}),
          64'd0);
  endtask

  initial begin
    longint unsigned sz;
    int c0;
    int t;

    // Reset state.
    tick(3);
    check("rst.flags",
          64'({sd_rd, sd_wr, bk_ena, bk_loading,
               bk_busy, bk_dirty, bk_done}),
          64'd0);
    check("rst.lba", 64'(sd_lba), 64'd0);
    RESET_n = 1'b1;
    tick(2);

    // Read-only image: nothing may start.
    downloading  = 1'b1;
    tick(2);
    img_readonly = 1'b1;
    img_mounted  = 1'b1;
    tick(1);
    img_mounted  = 1'b0;
    tick(1);
    check("ro.ena", 64'(bk_ena), 64'd0);
    img_size = 64'd32768;
    log_q.delete();
    c0 = done_cnt;
    downloading = 1'b0;
    tick(2);
    pulse_load();
    pulse_save();
    pulse_we();
    check("ro.dirty", 64'(bk_dirty), 64'd1);
    autosave_en = 1'b1;
    osd_status  = 1'b1;
    tick(2);
    osd_status  = 1'b0;
    autosave_en = 1'b0;
    expect_xfer("ro", 1'b0, 0, c0);
    img_readonly = 1'b0;

    // Mount, then short load at download end.
    img_size    = 64'd1000;
    downloading = 1'b1;
    tick(2);
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    tick(1);
    check("mnt.ena", 64'(bk_ena), 64'd1);
    log_q.delete();
    c0 = done_cnt;
    downloading = 1'b0;
    expect_xfer("short", 1'b0, n_of(64'd1000), c0);
    check("short.dirty", 64'(bk_dirty), 64'd0);

    // Manual save of a dirty NVRAM.
    pulse_we();
    check("sv.dirty1", 64'(bk_dirty), 64'd1);
    img_size = 64'd32768;
    log_q.delete();
    c0 = done_cnt;
    pulse_save();
    expect_xfer("save", 1'b1, 64, c0);
    check("sv.dirty0", 64'(bk_dirty), 64'd0);

    // Clamp to 64 sectors.
    img_size = 64'd1 << 20;
    log_q.delete();
    c0 = done_cnt;
    pulse_load();
    expect_xfer("clamp", 1'b0, 64, c0);

    // Random image sizes.
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0: sz = longint'($urandom_range(1, 40000));
        1: sz = {$urandom, $urandom};
        2: sz = longint'($urandom_range(0, 64)) * 512;
        default: sz = 0;
      endcase
      img_size = sz;
      log_q.delete();
      c0 = done_cnt;
      pulse_load();
      expect_xfer("rload", 1'b0, n_of(sz), c0);
    end

    // Zero-size image starts nothing.
    img_size = '0;
    log_q.delete();
    c0 = done_cnt;
    pulse_load();
    expect_xfer("zero", 1'b0, 0, c0);

    // Autosave on OSD open when dirty.
    pulse_we();
    autosave_en = 1'b1;
    log_q.delete();
    c0 = done_cnt;
    osd_status = 1'b1;
    tick(1);
    expect_xfer("auto", 1'b1, 64, c0);
    osd_status = 1'b0;
    tick(2);
    check("auto.clean", 64'(bk_dirty), 64'd0);
    log_q.delete();
    c0 = done_cnt;
    osd_status = 1'b1;
    tick(1);
    expect_xfer("auto0", 1'b1, 0, c0);
    osd_status  = 1'b0;
    autosave_en = 1'b0;

    // Load wins over save.
    img_size = 64'd2048;
    log_q.delete();
    c0 = done_cnt;
    bk_load = 1'b1;
    bk_save = 1'b1;
    tick(2);
    bk_load = 1'b0;
    bk_save = 1'b0;
    expect_xfer("coll", 1'b0, 4, c0);

    // Write during save redirties; load while busy dropped.
    log_q.delete();
    c0 = done_cnt;
    pulse_save();
    t = 0;
    while (log_q.size() < 5 && t < 500) begin
      tick(1);
      t++;
    end
    pulse_we();
    pulse_load();
    expect_xfer("wsave", 1'b1, 64, c0);
    check("wsave.dirty", 64'(bk_dirty), 64'd1);

    // New download clears the image; reload 1 sector.
    downloading = 1'b1;
    tick(2);
    check("dl.ena0", 64'(bk_ena), 64'd0);
    img_size    = 64'd512;
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
    log_q.delete();
    c0 = done_cnt;
    downloading = 1'b0;
    expect_xfer("one", 1'b0, 1, c0);

    // Reset mid-save at lba 10.
    log_q.delete();
    pulse_save();
    t = 0;
    while (log_q.size() < 11 && t < 500) begin
      tick(1);
      t++;
    end
    check("abort.reach", 64'(log_q.size()), 64'd11);
    ack_en  = 1'b0;
    RESET_n = 1'b0;
    tick(1);
    check("abort.req",
          64'({sd_rd, sd_wr, bk_busy}), 64'd0);
    RESET_n = 1'b1;
    log_q.delete();
    sd_ack = 1'b1;
    tick(22);
    check("abort.quiet", 64'(log_q.size()), 64'd0);
    check("abort.rdwr", 64'({sd_rd, sd_wr}), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
